// File: rtl/hazard_stall_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit_pkg
// Description : Shared ISA-level constants and the SRAM wait-state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_unit_pkg;

    localparam int c_LEN_REG_ADDRESS  = 5;
    localparam int c_SRAM_WAIT_CYCLES = 4;

    typedef enum logic [1:0] {
        SRAM_IDLE = 2'd0,
        SRAM_WAIT = 2'd1,
        SRAM_DONE = 2'd2
    } sram_state_t;

    // A write-enabled producer whose destination matches the source register.
    function automatic logic reg_dep(
        input logic [c_LEN_REG_ADDRESS-1:0] src,
        input logic [c_LEN_REG_ADDRESS-1:0] dest,
        input logic                         wb_en
    );
        return wb_en && (src == dest);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_unit_sram_wait_fsm.sv
`default_nettype none
// ============================================================================
// Module      : sram_wait_fsm
// Description : Holds the pipeline for SRAM_WAIT_CYCLES per memory access,
//               then releases for one cycle so the access can leave MEM.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_fsm
    import hazard_stall_unit_pkg::*;
#(
    parameter int SRAM_WAIT_CYCLES = c_SRAM_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_access_req,
    output logic sram_stall
);

    localparam int              c_CNT_W  = $clog2(SRAM_WAIT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(SRAM_WAIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(1);

    sram_state_t        r_state;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SRAM_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                SRAM_IDLE: begin
                    if (mem_access_req) begin
                        r_cnt   <= c_RELOAD;
                        r_state <= (SRAM_WAIT_CYCLES == 1) ? SRAM_DONE : SRAM_WAIT;
                    end
                end
                SRAM_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= SRAM_DONE;
                    end
                end
                // Request is ignored here so the finished access is not re-triggered.
                SRAM_DONE: r_state <= SRAM_IDLE;
                default:   r_state <= SRAM_IDLE;
            endcase
        end
    end

    assign sram_stall = (r_state == SRAM_WAIT) ||
                        ((r_state == SRAM_IDLE) && mem_access_req);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : RAW hazard detection, branch squash and SRAM wait-state
//               freeze/flush control for the IF/ID/EXE/MEM stage registers.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int SRAM_WAIT_CYCLES = c_SRAM_WAIT_CYCLES,
    parameter int STALL_CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [c_LEN_REG_ADDRESS-1:0] src1,
    input  logic [c_LEN_REG_ADDRESS-1:0] src2,
    input  logic                         two_src,
    input  logic [c_LEN_REG_ADDRESS-1:0] exe_dest,
    input  logic                         exe_wb_en,
    input  logic                         exe_mem_read,
    input  logic [c_LEN_REG_ADDRESS-1:0] mem_dest,
    input  logic                         mem_wb_en,
    input  logic                         forward_en,
    input  logic                         branch_taken,
    input  logic                         mem_access_req,
    output logic                         pc_freeze,
    output logic                         if_reg_freeze,
    output logic                         if_reg_flush,
    output logic                         id_reg_freeze,
    output logic                         id_reg_flush,
    output logic                         exe_reg_freeze,
    output logic                         mem_reg_freeze,
    output logic                         sram_busy,
    output logic [STALL_CNT_W-1:0]       stall_count
);

    logic w_sram_stall;
    logic w_hazard_nofwd;
    logic w_hazard_ldu;
    logic w_hazard;
    logic w_pc_freeze;
    logic [STALL_CNT_W-1:0] r_stall_count;

    sram_wait_fsm #(
        .SRAM_WAIT_CYCLES (SRAM_WAIT_CYCLES)
    ) u_sram_wait_fsm (
        .clk            (clk),
        .rst            (rst),
        .mem_access_req (mem_access_req),
        .sram_stall     (w_sram_stall)
    );

    assign w_hazard_nofwd = reg_dep(src1, exe_dest, exe_wb_en) ||
                            reg_dep(src1, mem_dest, mem_wb_en) ||
                            (two_src && (reg_dep(src2, exe_dest, exe_wb_en) ||
                                         reg_dep(src2, mem_dest, mem_wb_en)));

    // With forwarding only a load in EXE cannot supply its result in time.
    assign w_hazard_ldu = exe_wb_en && exe_mem_read &&
                          ((src1 == exe_dest) || (two_src && (src2 == exe_dest)));

    assign w_hazard = forward_en ? w_hazard_ldu : w_hazard_nofwd;

    assign w_pc_freeze    = w_sram_stall || (w_hazard && !branch_taken);
    assign pc_freeze      = w_pc_freeze;
    assign if_reg_freeze  = w_pc_freeze;
    assign if_reg_flush   = branch_taken && !w_sram_stall;
    assign id_reg_flush   = (branch_taken || w_hazard) && !w_sram_stall;
    assign id_reg_freeze  = w_sram_stall;
    assign exe_reg_freeze = w_sram_stall;
    assign mem_reg_freeze = w_sram_stall;
    assign sram_busy      = w_sram_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= '0;
        end else if (w_pc_freeze && (r_stall_count != {STALL_CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_unit
// Description : Scoreboard bench: stimulus pushes expected outputs from a
//               cycle-count reference model, a negedge monitor pops/compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    localparam int c_N   = 4;
    localparam int c_CW  = 6;
    localparam int c_MAX = (1 << c_CW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [4:0]      src1 = '0, src2 = '0, exe_dest = '0, mem_dest = '0;
    logic            two_src = 0, exe_wb_en = 0, exe_mem_read = 0, mem_wb_en = 0;
    logic            forward_en = 0, branch_taken = 0, mem_access_req = 0;
    logic            pc_freeze, if_reg_freeze, if_reg_flush, id_reg_freeze;
    logic            id_reg_flush, exe_reg_freeze, mem_reg_freeze, sram_busy;
    logic [c_CW-1:0] stall_count;

    hazard_stall_unit #(
        .SRAM_WAIT_CYCLES (c_N),
        .STALL_CNT_W      (c_CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .src1           (src1),
        .src2           (src2),
        .two_src        (two_src),
        .exe_dest       (exe_dest),
        .exe_wb_en      (exe_wb_en),
        .exe_mem_read   (exe_mem_read),
        .mem_dest       (mem_dest),
        .mem_wb_en      (mem_wb_en),
        .forward_en     (forward_en),
        .branch_taken   (branch_taken),
        .mem_access_req (mem_access_req),
        .pc_freeze      (pc_freeze),
        .if_reg_freeze  (if_reg_freeze),
        .if_reg_flush   (if_reg_flush),
        .id_reg_freeze  (id_reg_freeze),
        .id_reg_flush   (id_reg_flush),
        .exe_reg_freeze (exe_reg_freeze),
        .mem_reg_freeze (mem_reg_freeze),
        .sram_busy      (sram_busy),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n, req, br, fwd, two, ewb, emr, mwb;
        logic [4:0] s1, s2, ed, md;
    } stim_t;

    typedef struct {
        logic            pc_f, if_f, if_fl, id_f, id_fl, exe_f, mem_f, busy;
        logic [c_CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: cycles of stall still owed, and a pending release cycle.
    int   m_remaining = 0;
    bit   m_release   = 0;
    int   m_count     = 0;

    function automatic stim_t quiet();
        stim_t s;
        s       = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   hz, stall;
        rst = s.rst_n; mem_access_req = s.req; branch_taken = s.br;
        forward_en = s.fwd; two_src = s.two; exe_wb_en = s.ewb;
        exe_mem_read = s.emr; mem_wb_en = s.mwb;
        src1 = s.s1; src2 = s.s2; exe_dest = s.ed; mem_dest = s.md;
        if (!s.rst_n) begin
            m_remaining = 0; m_release = 0; m_count = 0;
        end
        if (s.fwd)
            hz = s.ewb && s.emr && ((s.s1 == s.ed) || (s.two && s.s2 == s.ed));
        else
            hz = (s.ewb && s.s1 == s.ed) || (s.mwb && s.s1 == s.md) ||
                 (s.two && ((s.ewb && s.s2 == s.ed) || (s.mwb && s.s2 == s.md)));
        if (m_release)            stall = 0;
        else if (m_remaining > 0) stall = 1;
        else                      stall = s.req;
        e.busy  = stall;
        e.pc_f  = stall || (hz && !s.br);
        e.if_f  = e.pc_f;
        e.if_fl = s.br && !stall;
        e.id_fl = (s.br || hz) && !stall;
        e.id_f  = stall;
        e.exe_f = stall;
        e.mem_f = stall;
        e.cnt   = c_CW'(m_count);
        q.push_back(e);
        if (s.rst_n) begin
            if (m_release) m_release = 0;
            else if (m_remaining > 0) begin
                m_remaining--;
                if (m_remaining == 0) m_release = 1;
            end else if (s.req) begin
                m_remaining = c_N - 1;
                if (m_remaining == 0) m_release = 1;
            end
            if (e.pc_f && m_count < c_MAX) m_count++;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("pc_freeze",      32'(pc_freeze),      32'(e.pc_f));
            check("if_reg_freeze",  32'(if_reg_freeze),  32'(e.if_f));
            check("if_reg_flush",   32'(if_reg_flush),   32'(e.if_fl));
            check("id_reg_freeze",  32'(id_reg_freeze),  32'(e.id_f));
            check("id_reg_flush",   32'(id_reg_flush),   32'(e.id_fl));
            check("exe_reg_freeze", 32'(exe_reg_freeze), 32'(e.exe_f));
            check("mem_reg_freeze", 32'(mem_reg_freeze), 32'(e.mem_f));
            check("sram_busy",      32'(sram_busy),      32'(e.busy));
            check("stall_count",    32'(stall_count),    32'(e.cnt));
        end
    end

    initial begin
        stim_t s;
        @(posedge clk);
        #1;
        s = quiet(); s.rst_n = 0;
        step(s); step(s);
        s = quiet(); step(s);

        // RAW hazard without forwarding, then the same with no write-back
        s = quiet(); s.s1 = 3; s.ed = 3; s.ewb = 1; step(s);
        s.ewb = 0; step(s);

        // Load-use through src2 with forwarding; non-load and MEM match do not stall
        s = quiet(); s.fwd = 1; s.two = 1; s.s2 = 5; s.ed = 5; s.ewb = 1; s.emr = 1; step(s);
        s.emr = 0; step(s);
        s = quiet(); s.fwd = 1; s.two = 1; s.s2 = 5; s.md = 5; s.mwb = 1; s.ed = 7; s.ewb = 1; step(s);

        // One access with the request held through stall and DONE
        s = quiet(); s.req = 1;
        repeat (c_N + 1) step(s);
        s = quiet(); step(s); step(s);

        // Branch during the wait: flush deferred to DONE
        s = quiet(); s.req = 1; step(s);
        s.br = 1; s.req = 0;
        repeat (c_N) step(s);
        s = quiet(); step(s);

        // Branch and load-use together in IDLE
        s = quiet(); s.br = 1; s.fwd = 1; s.s1 = 9; s.ed = 9; s.ewb = 1; s.emr = 1; step(s);

        // Reset in the second WAIT cycle, then a full access
        s = quiet(); s.req = 1; step(s); step(s);
        s = quiet(); s.rst_n = 0; step(s);
        s = quiet(); step(s);
        s.req = 1; step(s);
        s.req = 0; repeat (c_N + 1) step(s);

        for (int i = 0; i < 3000; i++) begin
            s       = quiet();
            s.rst_n = ($urandom_range(0, 299) != 0);
            s.req   = ($urandom_range(0, 3) == 0);
            s.br    = ($urandom_range(0, 5) == 0);
            s.fwd   = 1'($urandom);
            s.two   = 1'($urandom);
            s.ewb   = 1'($urandom);
            s.emr   = 1'($urandom);
            s.mwb   = 1'($urandom);
            s.s1    = 5'($urandom_range(0, 3));
            s.s2    = 5'($urandom_range(0, 3));
            s.ed    = 5'($urandom_range(0, 3));
            s.md    = 5'($urandom_range(0, 3));
            step(s);
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) check("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
